// File: rtl/selftrigger_record_capture.sv
// Self-trigger record capture.
// Keeps a circular history of enabled samples. On a trigger rising edge, once
// enough history exists, it captures a record of RECORD_LEN samples (PRETRIG of
// them before the trigger sample). The record is streamed as header,
// timestamp (4 words, MSW first), samples and trailer {ovr_rec, missed}.
//
// Ports:
//   clk, reset (async, active-low)
//   enable      sample-valid qualifier for din / trigger_in
//   din         16-bit sample, trigger_in level trigger, timestamp 64-bit time
//   m_data/m_valid/m_ready/m_last  registered valid/ready output stream
//   busy        record in progress (POST or READOUT)
//   overrun     sticky: some record was overwritten before being read
module selftrigger_record_capture #(
  parameter int unsigned PRETRIG    = 64,
  parameter int unsigned RECORD_LEN = 256,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [15:0] HEADER     = 16'hA55A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] din,
  input  logic        trigger_in,
  input  logic [63:0] timestamp,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FW     = $clog2(PRETRIG + 1);
  localparam int unsigned RW     = $clog2(RECORD_LEN);
  localparam int unsigned NWORDS = RECORD_LEN + 6;
  localparam int unsigned XW     = $clog2(NWORDS + 1);
  localparam int unsigned MW     = 15;

  typedef enum logic [1:0] {IDLE, POST, READOUT} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     rdata_q;
  logic [AW-1:0]   wptr_q, rptr_q, start_q, ra_c, dist_c;
  logic [FW-1:0]   fill_q;
  logic            trig_d_q;
  logic [63:0]     ts_q;
  logic [RW-1:0]   remaining_q;
  logic [XW-1:0]   widx_q;
  logic [MW-1:0]   missed_q;
  logic            ovr_rec_q;
  logic [15:0]     word_c;
  logic            edge_c, take_c, missed_inc_c, accept_c;
  logic            load_c, is_sample_c, sample_rd_c, unread_c, ovr_hit_c;

  // Trigger qualification and stream handshake strobes.
  assign edge_c       = trigger_in & ~trig_d_q & enable;
  assign take_c       = (state_q == IDLE) & edge_c & (fill_q == FW'(PRETRIG));
  assign missed_inc_c = edge_c & ~take_c;
  assign accept_c     = m_valid & m_ready & m_last;

  // Word generator advances whenever the output register is free or draining.
  assign load_c      = (state_q == READOUT) & (widx_q < XW'(NWORDS)) & (~m_valid | m_ready);
  assign is_sample_c = (widx_q >= XW'(5)) & (widx_q < XW'(RECORD_LEN + 5));
  assign sample_rd_c = load_c & is_sample_c;
  assign unread_c    = (state_q == READOUT) & (widx_q < XW'(RECORD_LEN + 5));

  // rdata_q always holds mem[rptr_q]: the read address is the pointer's next value.
  assign ra_c = (state_q != READOUT) ? start_q :
                (sample_rd_c ? rptr_q + AW'(1) : rptr_q);

  // Writer is one write away from reaching the oldest unread sample.
  assign dist_c    = wptr_q - rptr_q;
  assign ovr_hit_c = unread_c & enable & (dist_c == AW'(DEPTH - 1)) & ~sample_rd_c;

  // Next stream word.
  always_comb begin
    word_c = rdata_q;
    if (widx_q == XW'(0))               word_c = HEADER;
    else if (widx_q == XW'(1))          word_c = ts_q[63:48];
    else if (widx_q == XW'(2))          word_c = ts_q[47:32];
    else if (widx_q == XW'(3))          word_c = ts_q[31:16];
    else if (widx_q == XW'(4))          word_c = ts_q[15:0];
    else if (widx_q == XW'(NWORDS - 1)) word_c = {ovr_rec_q, missed_q};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_c) state_d = POST;
      POST: begin
        if (remaining_q == '0)                         state_d = READOUT;
        else if (enable && remaining_q == RW'(1))      state_d = READOUT;
      end
      READOUT: if (accept_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sample buffer; left unreset on purpose.
  always_ff @(posedge clk) begin
    if (enable) mem[wptr_q] <= din;
    rdata_q <= mem[ra_c];
  end

  // Write side, trigger capture and record bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      start_q     <= '0;
      fill_q      <= '0;
      trig_d_q    <= 1'b0;
      ts_q        <= '0;
      remaining_q <= '0;
      widx_q      <= '0;
      missed_q    <= '0;
      ovr_rec_q   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (enable) begin
        wptr_q   <= wptr_q + AW'(1);
        trig_d_q <= trigger_in;
        if (fill_q != FW'(PRETRIG)) fill_q <= fill_q + FW'(1);
      end

      if (take_c) begin
        start_q     <= wptr_q - AW'(PRETRIG);
        ts_q        <= timestamp;
        remaining_q <= RW'(RECORD_LEN - PRETRIG - 1);
      end else if (state_q == POST && enable && remaining_q != '0) begin
        remaining_q <= remaining_q - RW'(1);
      end

      rptr_q <= ra_c;

      if (state_q != READOUT) widx_q <= '0;
      else if (load_c)        widx_q <= widx_q + XW'(1);

      // An edge coinciding with trailer acceptance belongs to the next record.
      if (accept_c)                            missed_q <= missed_inc_c ? MW'(1) : '0;
      else if (missed_inc_c && missed_q != '1) missed_q <= missed_q + MW'(1);

      if (accept_c)       ovr_rec_q <= 1'b0;
      else if (ovr_hit_c) ovr_rec_q <= 1'b1;

      if (ovr_hit_c) overrun <= 1'b1;

      busy <= (state_d != IDLE);
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load_c) begin
      m_data  <= word_c;
      m_valid <= 1'b1;
      m_last  <= (widx_q == XW'(NWORDS - 1));
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_selftrigger_record_capture.sv
// Directed bench for selftrigger_record_capture: ramp data, record framing,
// missed-trigger counting, stalls, overrun and mid-record reset.
module tb_selftrigger_record_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] din;
  logic        trigger_in;
  logic [63:0] timestamp;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        overrun;

  selftrigger_record_capture dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .din        (din),
    .trigger_in (trigger_in),
    .timestamp  (timestamp),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wcount = 0;
  logic [15:0] got  [300];
  logic        gotl [300];
  int          got_n, first_valid, first_hs, last_hs, stall_bad;
  bit          done;
  int          trig_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, then the ramp advances.
  task automatic tick();
    @(posedge clk);
    if (enable) wcount++;
    #1;
    din = 16'(wcount);
  endtask

  task automatic run_to(input int target);
    while (wcount < target) tick();
  endtask

  // Collect one record; mode 1 randomises m_ready. Trigger pulses at cycles p1..p3.
  task automatic collect(input int mode, input int p1, input int p2, input int p3,
                         input int max_cyc);
    logic [15:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    got_n = 0; first_valid = -1; first_hs = -1; last_hs = -1; stall_bad = 0; done = 0;
    prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 300; i++) begin got[i] = '0; gotl[i] = 1'b0; end
    for (int c = 0; c < max_cyc && !done; c++) begin
      trigger_in = (c == p1) || (c == p2) || (c == p3);
      m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stall_bad++;
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready && got_n < 300) begin
        got[got_n]  = m_data;
        gotl[got_n] = m_last;
        got_n++;
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        if (m_last) done = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      tick();
    end
    trigger_in = 1'b0;
    chk("record_done", 64'(done), 64'd1);
  endtask

  task automatic check_record(input string nm, input logic [63:0] ets, input int efirst,
                              input logic [15:0] etr, input bit samples);
    int bad, nl;
    chk({nm, "_count"}, 64'(got_n), 64'd262);
    chk({nm, "_header"}, 64'(got[0]), 64'hA55A);
    chk({nm, "_ts"}, {got[1], got[2], got[3], got[4]}, ets);
    if (samples) begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (got[5+i] !== 16'(efirst + i)) bad++;
      chk({nm, "_samples_bad"}, 64'(bad), 64'd0);
    end
    chk({nm, "_trailer"}, 64'(got[261]), 64'(etr));
    nl = 0;
    for (int i = 0; i < 300; i++) nl += int'(gotl[i]);
    chk({nm, "_last_count"}, 64'(nl), 64'd1);
    chk({nm, "_last_pos"}, 64'(gotl[261]), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; din = '0; trigger_in = 1'b0;
    timestamp = 64'h0123_4567_89AB_CDEF; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b1; enable = 1'b1; wcount = 0; din = '0;

    // Ramp record: trigger sample 500 -> samples 436..691, trailer 0.
    run_to(500);
    trigger_in = 1'b1;
    chk("A_busy_before", 64'(busy), 64'd0);
    tick();
    chk("A_busy_after_edge", 64'(busy), 64'd1);
    collect(0, -1, -1, -1, 600);
    check_record("A", 64'h0123_4567_89AB_CDEF, 436, 16'h0000, 1'b1);
    chk("A_hdr_latency_ok", 64'(first_valid > 0 && first_valid <= 193), 64'd1);
    chk("A_no_bubbles", 64'(last_hs - first_hs), 64'd261);
    chk("A_busy_done", 64'(busy), 64'd0);
    chk("A_valid_done", 64'(m_valid), 64'd0);

    // Two edges in POST, one in READOUT -> trailer 3.
    timestamp = 64'hFEDC_BA98_7654_3210;
    trig_w = wcount;
    trigger_in = 1'b1;
    tick();
    collect(0, 10, 50, 200, 700);
    check_record("C", 64'hFEDC_BA98_7654_3210, trig_w - 64, 16'h0003, 1'b1);

    // Random back-pressure, missed count back to 0.
    timestamp = 64'h1111_2222_3333_4444;
    trig_w = wcount;
    trigger_in = 1'b1;
    tick();
    collect(1, -1, -1, -1, 3000);
    check_record("D", 64'h1111_2222_3333_4444, trig_w - 64, 16'h0000, 1'b1);
    chk("D_stall_stable_bad", 64'(stall_bad), 64'd0);

    // Overrun: ready low, writes continue; 768th write past record end sets it.
    timestamp = 64'hDEAD_BEEF_0000_0001;
    m_ready = 1'b0;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    repeat (191) tick();
    repeat (767) tick();
    chk("E_overrun_767", 64'(overrun), 64'd0);
    chk("E_stalled_valid", 64'(m_valid), 64'd1);
    chk("E_stalled_header", 64'(m_data), 64'hA55A);
    tick();
    chk("E_overrun_768", 64'(overrun), 64'd1);
    enable = 1'b0;
    collect(0, -1, -1, -1, 600);
    check_record("E", 64'hDEAD_BEEF_0000_0001, 0, 16'h8000, 1'b0);
    chk("E_overrun_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of sample readout.
    enable = 1'b1;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    m_ready = 1'b1;
    repeat (250) tick();
    chk("R_streaming", 64'(m_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("R_valid_async", 64'(m_valid), 64'd0);
    chk("R_busy_async", 64'(busy), 64'd0);
    chk("R_overrun_clr", 64'(overrun), 64'd0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    wcount = 0; din = '0;
    reset = 1'b1; enable = 1'b1;

    // Edges with 10 and 63 samples of history are missed; 65 is accepted.
    timestamp = 64'h0000_0000_0000_00A5;
    run_to(10);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    chk("R_busy_fill10", 64'(busy), 64'd0);
    run_to(63);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    chk("R_busy_fill63", 64'(busy), 64'd0);
    tick();
    trigger_in = 1'b1;
    tick();
    chk("R_busy_fill64", 64'(busy), 64'd1);
    collect(0, -1, -1, -1, 600);
    check_record("R", 64'h0000_0000_0000_00A5, 1, 16'h0002, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/selftrigger_record_capture.md
# selftrigger_record_capture

Captures fixed-length waveform records around self-trigger events and streams them out as framed 16-bit words. Sits directly downstream of the IIR/moving-mean/CFD self-trigger stage: `din` is that stage's `y` output and `trigger_in` is its `trigger` output. A circular sample buffer supplies pre-trigger history. Each record is emitted on a valid/ready stream as header, timestamp, samples and trailer.

## Interface
- `PRETRIG`, 64: samples in the record that precede the trigger sample.
- `RECORD_LEN`, 256: total samples per record. Constraint: `PRETRIG < RECORD_LEN`.
- `DEPTH`, 1024: circular buffer depth. Power of 2, `>= 2*RECORD_LEN`.
- `HEADER`, 16'hA55A: first word of every record.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  sample-valid qualifier. No writes or trigger detection when low.
- `din`  in  16  signed sample from the trigger stage.
- `trigger_in`  in  1  level trigger from the trigger stage. Only its rising edge is used.
- `timestamp`  in  64  free-running time counter.
- `m_data`  out  16  stream word.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  high on the trailer word.
- `busy`  out  1  high in POST or READOUT.
- `overrun`  out  1  sticky: some record was corrupted by overwrite. Cleared only by reset.

## Operation
- Write side runs in every state. On each clk with `enable=1`, `din` is written at `wptr`, then `wptr` increments modulo DEPTH.
- `fill` counter saturates at PRETRIG. A trigger is ignored until `fill == PRETRIG`.
- Edge detect: `trig_d <= trigger_in` on enabled cycles. An edge is `trigger_in & ~trig_d & enable`.
- FSM states: IDLE, POST, READOUT.
- IDLE → POST, on an edge at edge k with `fill == PRETRIG`:
  - the sample written at edge k (address W) is the trigger sample;
  - `start = W-PRETRIG` (mod DEPTH);
  - latch `ts = timestamp` sampled at edge k;
  - `remaining = RECORD_LEN-PRETRIG-1`.
- POST: decrement `remaining` on each enabled write. When the write of address `start+RECORD_LEN-1` completes, go to READOUT with `rptr = start`. If `remaining == 0` at entry, go straight to READOUT on the next cycle.
- READOUT word sequence:
  1. `HEADER`;
  2. `ts[63:48]`, `ts[47:32]`, `ts[31:16]`, `ts[15:0]`;
  3. RECORD_LEN samples from `rptr` upward;
  4. trailer `{ovr_rec, missed[14:0]}` with `m_last=1`.
  - Total is RECORD_LEN+6 words.
- After the trailer handshake, return to IDLE and clear `ovr_rec`.
- Missed triggers: an edge while in POST or READOUT, or in IDLE with fill incomplete, increments `missed`. `missed` saturates at 0x7FFF and clears on trailer acceptance. If an edge occurs in the same cycle as trailer acceptance, it counts toward the next record.
- Overrun:
  - `d = (wptr - rptr) mod DEPTH`, counted over unread record samples during READOUT.
  - If an enabled write occurs while `d == DEPTH-1` and no sample is read that cycle, set `ovr_rec` and `overrun`.
  - Readout continues with full word count; data may be corrupt.
- `enable=0` in POST stalls the POST count. In READOUT it has no effect on the stream.
- Reset mid-record: all state is cleared immediately (IDLE, `fill=0`, `wptr=0`, `missed=0`). The partial stream is abandoned: `m_valid` drops asynchronously, with no trailer.

## Timing
- Reset values: `m_data=0`, `m_valid=0`, `m_last=0`, `busy=0`, `overrun=0`. State is IDLE, all pointers and counters are 0.
- `busy` rises one cycle after the trigger edge and falls the cycle after trailer acceptance.
- First `m_valid` (HEADER) appears no later than 2 cycles after the last record sample is written.
- Standard valid/ready:
  - `m_data` and `m_last` are held stable while `m_valid & ~m_ready`;
  - `m_valid` never drops without a handshake, except on reset.
- With `m_ready` held high, throughput is 1 word per cycle with no bubbles: RAM read latency is hidden by prefetch.
- Outputs are registered. No combinational path from `m_ready` to `m_valid` or `m_data`.
- A new trigger is accepted from the cycle after trailer acceptance.

## Test plan
- Ramp `din = 0,1,2,...` (`enable=1`), trigger edge with `din=500`, `timestamp=0x0123456789ABCDEF` → 262 words:
  - 0xA55A, 0x0123, 0x4567, 0x89AB, 0xCDEF;
  - samples 436..691;
  - trailer 0x0000 with `m_last`.
- Trigger edge after only 10 enabled samples post-reset → no record. Next valid record's trailer = 0x0001.
- Two extra edges during POST plus one during READOUT, then record → trailer 0x0003. Following record trailer 0x0000.
- `m_ready` low throughout READOUT while writes continue → after 768 writes past record end, `overrun=1`. Trailer bit 15 = 1. Word count still 262.
- `m_ready` toggling pseudo-randomly → data stable during stalls, exact same 262-word sequence as the unstalled run.
- Assert `reset` low in the middle of sample readout → `m_valid=0`, `busy=0` immediately. The next trigger needs 64 fresh samples. The next record is correct.
